// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Output stage of the 32-bit ALU. Each accepted ALU result is captured with its
// op code and two derived flags (zero, neg) into a 2-entry skid buffer, then
// presented downstream through a valid/ready handshake. Completed output
// handshakes are counted in xfer_count.
//
// Optional feature macro: ALU_RESULT_STICKY_EN
//   When defined, adds sticky_clr / sticky_zero / sticky_neg. Each sticky bit
//   accumulates (ORs) the zero/neg flag of every popped entry until cleared.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         synchronous, active-high reset
//   in_valid    ALU result on in_result/in_alu is valid
//   in_ready    stage can accept an entry this cycle (registered occupancy only)
//   in_result   ALU result
//   in_alu      ALU op code (00 add, 01 sub, 10 and, 11 or)
//   out_valid   head entry available
//   out_ready   consumer accepts head entry
//   out_result  head entry result (0 when out_valid=0)
//   out_op      head entry op code (0 when out_valid=0)
//   out_zero    head entry zero flag (0 when out_valid=0)
//   out_neg     head entry sign flag (0 when out_valid=0)
//   sticky_clr  (macro only) clear both sticky bits; wins over a same-cycle pop
//   sticky_zero (macro only) some popped entry had zero=1 since last clear
//   sticky_neg  (macro only) some popped entry had neg=1 since last clear
//   xfer_count  completed output handshakes, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [1:0]       in_alu,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
`ifdef ALU_RESULT_STICKY_EN
    input  logic             sticky_clr,
    output logic             sticky_zero,
    output logic             sticky_neg,
`endif
    output logic [CNT_W-1:0] xfer_count
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [1:0]       op;
        logic             zero;
        logic             neg;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    // Flags are derived once at capture so the output side is a pure register read.
    function automatic entry_t make_entry(input logic [WIDTH-1:0] result,
                                          input logic [1:0]       op);
        entry_t e;
        e.result = result;
        e.op     = op;
        e.zero   = (result == '0);
        e.neg    = result[WIDTH-1];
        return e;
    endfunction

    occ_t       occ_q, occ_d;
    entry_t     head_p0, tail_p0;
    entry_t     new_entry;
    logic       push, pop;
    logic       load_head, load_tail, promote;
    logic [CNT_W-1:0] xfer_q;

    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign new_entry = make_entry(in_result, in_alu);

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Occupancy next-state plus the slot-steering strobes. The head slot is
    // always the oldest entry; the tail slot only holds data when FULL.
    always_comb begin
        occ_d     = occ_q;
        load_head = 1'b0;
        load_tail = 1'b0;
        promote   = 1'b0;
        case (occ_q)
            EMPTY: begin
                if (push) begin
                    occ_d     = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    occ_d     = FULL;
                    load_tail = 1'b1;
                end else if (pop) begin
                    occ_d     = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    occ_d   = ONE;
                    promote = 1'b1;
                end
            end
            default: begin
                occ_d = EMPTY;
            end
        endcase
    end

    // ---- stage p0: entry storage (data only, qualified by occupancy) ----
    always_ff @(posedge clk) begin
        if (load_head) begin
            head_p0 <= new_entry;
        end else if (promote) begin
            head_p0 <= tail_p0;
        end
        if (load_tail) begin
            tail_p0 <= new_entry;
        end
    end

    assign out_result = out_valid ? head_p0.result : '0;
    assign out_op     = out_valid ? head_p0.op     : 2'b00;
    assign out_zero   = out_valid & head_p0.zero;
    assign out_neg    = out_valid & head_p0.neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_q <= '0;
        end else if (pop) begin
            xfer_q <= xfer_q + CNT_W'(1);
        end
    end

    assign xfer_count = xfer_q;

`ifdef ALU_RESULT_STICKY_EN
    logic sticky_zero_q, sticky_neg_q;

    always_ff @(posedge clk) begin
        if (rst || sticky_clr) begin
            sticky_zero_q <= 1'b0;
            sticky_neg_q  <= 1'b0;
        end else if (pop) begin
            sticky_zero_q <= sticky_zero_q | head_p0.zero;
            sticky_neg_q  <= sticky_neg_q  | head_p0.neg;
        end
    end

    assign sticky_zero = sticky_zero_q;
    assign sticky_neg  = sticky_neg_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [1:0]       in_alu;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [1:0]       out_op;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] xfer_count;
`ifdef ALU_RESULT_STICKY_EN
    logic             sticky_clr;
    logic             sticky_zero;
    logic             sticky_neg;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_alu     (in_alu),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
`ifdef ALU_RESULT_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky_zero(sticky_zero),
        .sticky_neg (sticky_neg),
`endif
        .xfer_count (xfer_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_result = '0; in_alu = 2'b00;
`ifdef ALU_RESULT_STICKY_EN
        sticky_clr = 1'b0;
`endif
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_result = 32'h1234_5678; in_alu = 2'b11;
`ifdef ALU_RESULT_STICKY_EN
        sticky_clr = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (xfer_count !== 4'd0) begin bad++; $display("FAIL reset_xfer got=%0d exp=0", xfer_count); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_result = 32'h0000_0005; in_alu = 2'b00; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_result !== 32'h5) begin bad++; $display("FAIL single_result got=%h exp=5", out_result); end
        total++; if (out_op !== 2'b00) begin bad++; $display("FAIL single_op got=%b exp=00", out_op); end
        total++; if ({out_zero, out_neg} !== 2'b00) begin bad++; $display("FAIL single_flags got=%b exp=00", {out_zero, out_neg}); end
        tick();
        total++; if (xfer_count !== 4'd1) begin bad++; $display("FAIL single_xfer got=%0d exp=1", xfer_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after got=%b exp=0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL single_result_after got=%h exp=0", out_result); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 32'h8000_0000; in_alu = 2'b01;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        in_result = 32'h0000_0000; in_alu = 2'b10;
        tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, out_result, out_op, out_zero, out_neg} !== {1'b1, 32'h8000_0000, 2'b01, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b/%h/%b/%b/%b exp=1/80000000/01/0/1",
                         i, out_valid, out_result, out_op, out_zero, out_neg);
            end
            tick();
        end
        out_ready = 1'b1;
        total++; if (out_result !== 32'h8000_0000) begin bad++; $display("FAIL bp_first got=%h exp=80000000", out_result); end
        tick();
        total++;
        if ({out_valid, out_result, out_op, out_zero, out_neg} !== {1'b1, 32'h0, 2'b10, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL bp_second got=%b/%h/%b/%b/%b exp=1/00000000/10/1/0",
                     out_valid, out_result, out_op, out_zero, out_neg);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
        total++; if (xfer_count !== 4'd2) begin bad++; $display("FAIL bp_xfer got=%0d exp=2", xfer_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_result = 32'(i); in_alu = 2'b00;
            tick();
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
            total++;
            if ({out_valid, out_result} !== {1'b1, 32'(i)}) begin
                bad++;
                $display("FAIL b2b_result%0d got=%b/%0d exp=1/%0d", i, out_valid, out_result, i);
            end
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
        total++; if (xfer_count !== 4'd10) begin bad++; $display("FAIL b2b_xfer got=%0d exp=10", xfer_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_result = 32'h0000_0007; in_alu = 2'b00;
        tick();
        out_ready = 1'b0;
        tick(); tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b exp=0", in_ready); end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_result = 32'h0000_0009;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
        total++; if (xfer_count !== 4'd0) begin bad++; $display("FAIL mid_xfer got=%0d exp=0", xfer_count); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_retained got=%b exp=0", out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_result = 32'h0000_0001; in_alu = 2'b00;
        tick();
        for (int k = 1; k <= 17; k++) begin
            in_result = 32'(k + 1);
            tick();
            total++;
            if (xfer_count !== 4'(k % 16)) begin
                bad++;
                $display("FAIL wrap_pop%0d got=%0d exp=%0d", k, xfer_count, k % 16);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

`ifdef ALU_RESULT_STICKY_EN
    task automatic test_sticky();
        do_reset();
        total++; if ({sticky_zero, sticky_neg} !== 2'b00) begin bad++; $display("FAIL sticky_reset got=%b exp=00", {sticky_zero, sticky_neg}); end
        out_ready = 1'b0; in_valid = 1'b1; in_result = 32'h0000_0000; in_alu = 2'b10;
        tick();
        in_result = 32'hFFFF_FFFF; in_alu = 2'b11;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        total++; if ({sticky_zero, sticky_neg} !== 2'b10) begin bad++; $display("FAIL sticky_first got=%b exp=10", {sticky_zero, sticky_neg}); end
        tick();
        total++; if ({sticky_zero, sticky_neg} !== 2'b11) begin bad++; $display("FAIL sticky_both got=%b exp=11", {sticky_zero, sticky_neg}); end
        out_ready = 1'b0; in_valid = 1'b1; in_result = 32'h0000_0000; in_alu = 2'b00;
        tick();
        in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0; out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sticky_clr_pop got=%b exp=0", out_valid); end
        total++; if ({sticky_zero, sticky_neg} !== 2'b00) begin bad++; $display("FAIL sticky_clr_wins got=%b exp=00", {sticky_zero, sticky_neg}); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
`ifdef ALU_RESULT_STICKY_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
